// File: rtl/safe_code_tx.sv
// safe_code_tx: keypad-side transmitter for the safe lock serial protocol.
// Takes a parallel entry code, shifts it MSB-first toward the lock, collects
// the lock's verdict, reports it to the panel and enforces a retry lockout.
// Optional build macro: TX_TIMEOUT_EN adds a response timeout in WAIT_RESP
// (a silent lock counts as a failure after RESP_TIMEOUT cycles).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once valid is raised it holds, with its data stable, until that
// edge. Ready never depends on the partner's valid in the same cycle.
module safe_code_tx #(
    parameter int CODE_W         = 4,
    parameter int GAP_CYCLES     = 1,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int RESP_TIMEOUT   = 8,
    localparam int FW            = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              code_val,
    input  logic [CODE_W-1:0] code_data,
    output logic              code_ready,
    output logic              ser_val,
    output logic              ser_data,
    input  logic              ser_ready,
    input  logic              output_val,
    input  logic              output_data,
    output logic              result_val,
    output logic              result_ok,
    output logic              locked_out,
    output logic [FW-1:0]     fail_cnt,
    output logic [2:0]        state_dbg
);

    localparam int IW   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int TM1  = (GAP_CYCLES > LOCKOUT_CYCLES) ? GAP_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX = (TM1 > RESP_TIMEOUT) ? TM1 : RESP_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        GAP       = 3'd2,
        WAIT_RESP = 3'd3,
        REPORT    = 3'd4,
        LOCKOUT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic [CW-1:0]     tmr;
    logic              verdict;
    logic [FW-1:0]     fail_nxt;

    // control strobes from the FSM to the datapath
    logic ld_code, bit_adv, tmr_clr, tmr_inc, vd_ld, vd_val, fc_clr, fc_inc;

    assign state_dbg = state_q;
    assign fail_nxt  = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state, outputs and datapath strobes
    always_comb begin
        state_d    = state_q;
        ld_code    = 1'b0;
        bit_adv    = 1'b0;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        vd_ld      = 1'b0;
        vd_val     = output_data;
        fc_clr     = 1'b0;
        fc_inc     = 1'b0;
        // code_ready is gated by rstn so every output reads 0 while in reset
        code_ready = (state_q == IDLE) && rstn;
        ser_val    = 1'b0;
        ser_data   = 1'b0;
        result_val = 1'b0;
        result_ok  = 1'b0;
        locked_out = 1'b0;
        case (state_q)
            IDLE: begin
                // output_val here is spurious and deliberately ignored
                if (code_val) begin
                    ld_code = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                ser_val  = 1'b1;
                ser_data = shreg[bit_idx];
                // an early verdict wins over a bit handshake in the same cycle
                if (output_val) begin
                    vd_ld   = 1'b1;
                    state_d = REPORT;
                end else if (ser_ready) begin
                    if (bit_idx == '0) begin
                        tmr_clr = 1'b1;
                        state_d = WAIT_RESP;
                    end else begin
                        bit_adv = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            tmr_clr = 1'b1;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (output_val) begin
                    vd_ld   = 1'b1;
                    state_d = REPORT;
                end else if (int'(tmr) + 1 >= GAP_CYCLES) begin
                    state_d = SEND;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (output_val) begin
                    vd_ld   = 1'b1;
                    state_d = REPORT;
                end
`ifdef TX_TIMEOUT_EN
                // tmr is 0 in the first WAIT_RESP cycle, so REPORT lands
                // exactly RESP_TIMEOUT cycles after the last-bit transfer
                else if (int'(tmr) + 2 >= RESP_TIMEOUT) begin
                    vd_ld   = 1'b1;
                    vd_val  = 1'b0;
                    state_d = REPORT;
                end else begin
                    tmr_inc = 1'b1;
                end
`endif
            end
            REPORT: begin
                result_val = 1'b1;
                result_ok  = verdict;
                if (verdict) begin
                    fc_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    fc_inc = 1'b1;
                    if (fail_nxt == FW'(MAX_FAIL)) begin
                        tmr_clr = 1'b1;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                locked_out = 1'b1;
                if (int'(tmr) + 1 >= LOCKOUT_CYCLES) begin
                    fc_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // shift register, bit index, shared timer, verdict latch, failure count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg    <= '0;
            bit_idx  <= '0;
            tmr      <= '0;
            verdict  <= 1'b0;
            fail_cnt <= '0;
        end else begin
            if (ld_code) begin
                shreg   <= code_data;
                bit_idx <= IW'(CODE_W - 1);
            end else if (bit_adv) begin
                bit_idx <= bit_idx - 1'b1;
            end
            if (tmr_clr)      tmr <= '0;
            else if (tmr_inc) tmr <= tmr + 1'b1;
            if (vd_ld) verdict <= vd_val;
            if (fc_clr)      fail_cnt <= '0;
            else if (fc_inc) fail_cnt <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_safe_code_tx.sv
// tb_safe_code_tx: bench for safe_code_tx. The bench plays the lock: it
// accepts serial bits, rejects at the first wrong bit (or lazily at the end),
// and tracks expected bits, verdicts, failure count and lockout.
module tb_safe_code_tx;

    localparam int CODE_W         = 4;
    localparam int GAP_CYCLES     = 1;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int RESP_TIMEOUT   = 8;
    localparam int FW             = $clog2(MAX_FAIL + 1);
    localparam logic [CODE_W-1:0] SECRET = 4'b1011;

    // clock / reset
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              code_val, code_ready;
    logic [CODE_W-1:0] code_data;
    logic              ser_val, ser_data, ser_ready;
    logic              output_val, output_data;
    logic              result_val, result_ok, locked_out;
    logic [FW-1:0]     fail_cnt;
    logic [2:0]        state_dbg;

    safe_code_tx #(
        .CODE_W(CODE_W), .GAP_CYCLES(GAP_CYCLES), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .code_val(code_val), .code_data(code_data), .code_ready(code_ready),
        .ser_val(ser_val), .ser_data(ser_data), .ser_ready(ser_ready),
        .output_val(output_val), .output_data(output_data),
        .result_val(result_val), .result_ok(result_ok), .locked_out(locked_out),
        .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    // scoreboard
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_fails = 0;
    logic exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver: one code entry plus lock behaviour
    //  n_bits  : bits the lock takes before it answers
    //  verdict : lock answer (ignored when silent)
    //  delay   : cycles the lock waits before answering
    //  rnd     : random ser_ready stalls
    //  stall_at: bits sent before a forced 3-cycle stall (0 = none)
    //  rst_at  : bits sent before a reset pulse in the following gap (0 = none)
    //  silent  : lock never answers
    task automatic run_txn(input logic [CODE_W-1:0] code, input int n_bits, input logic verdict,
                           input int delay, input bit rnd, input int stall_at,
                           input int rst_at, input bit silent);
        int   cyc, sent, gap_run, wait_cyc, stall_left, dly, lock_len;
        bit   verdict_sent, prev_stall, done, rdy;
        logic prev_data, sv, sd, rv, exp_bit, exp_ok;
        cyc = 0;
        while (!code_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("code_ready_wait", code_ready, 1);
        if (!code_ready) return;
        exp_q.delete();
        for (int i = CODE_W - 1; i >= CODE_W - n_bits; i--) exp_q.push_back(code[i]);
        exp_ok    = silent ? 1'b0 : verdict;
        code_val  = 1'b1;
        code_data = code;
        @(negedge clk);
        code_val  = 1'b0;
        code_data = CODE_W'($urandom);
        check("first_ser_val", ser_val, 1);
        sent = 0; gap_run = -1; wait_cyc = 0; dly = delay; cyc = 0;
        stall_left = (stall_at > 0) ? 3 : 0;
        verdict_sent = 0; prev_stall = 0; prev_data = 1'b0; done = 0;
        while (!done && cyc < 200) begin
            sv = ser_val; sd = ser_data; rv = result_val;
            ser_ready = 1'b0; output_val = 1'b0; output_data = 1'b0;
            if (sent == CODE_W) wait_cyc++;
            if (verdict_sent || (silent && wait_cyc == RESP_TIMEOUT)) begin
                check("result_val", rv, 1);
                check("result_ok", result_ok, exp_ok);
                check("ser_val_at_report", sv, 0);
                done = 1;
            end else begin
                check("no_result_yet", rv, 0);
                if (prev_stall) begin
                    check("stall_hold_val", sv, 1);
                    check("stall_hold_data", sd, prev_data);
                end
                prev_stall = 0;
                if (sent == n_bits) begin
                    if (n_bits == CODE_W) check("ser_val_after_last", sv, 0);
                    if (!silent) begin
                        if (dly == 0) begin
                            output_val   = 1'b1;
                            output_data  = verdict;
                            verdict_sent = 1;
                        end else begin
                            dly--;
                        end
                    end
                end else if (rst_at > 0 && sent == rst_at && !sv) begin
                    rstn = 1'b0;
                    #1;
                    check("rst_ser_val", ser_val, 0);
                    check("rst_ser_data", ser_data, 0);
                    check("rst_code_ready", code_ready, 0);
                    check("rst_result_val", result_val, 0);
                    check("rst_result_ok", result_ok, 0);
                    check("rst_locked_out", locked_out, 0);
                    check("rst_fail_cnt", fail_cnt, 0);
                    exp_q.delete();
                    exp_fails = 0;
                    @(negedge clk);
                    rstn = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        check("no_result_after_reset", result_val, 0);
                        check("idle_after_reset", ser_val, 0);
                    end
                    return;
                end else if (sv) begin
                    if (gap_run >= 0) check("gap_len", gap_run, GAP_CYCLES);
                    gap_run = -1;
                    if (stall_at > 0 && sent == stall_at && stall_left > 0) begin
                        rdy = 0;
                        stall_left--;
                    end else begin
                        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    if (rdy) begin
                        exp_bit = exp_q.pop_front();
                        check("ser_data", sd, exp_bit);
                        sent++;
                        if (sent < CODE_W) gap_run = 0;
                    end
                    prev_stall = !rdy;
                    prev_data  = sd;
                    ser_ready  = rdy;
                end else if (gap_run >= 0) begin
                    gap_run++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        ser_ready = 1'b0; output_val = 1'b0;
        check("txn_done", done, 1);
        if (!done) return;
        check("bits_consumed", exp_q.size(), 0);
        if (exp_ok) exp_fails = 0;
        else        exp_fails = (exp_fails < MAX_FAIL) ? exp_fails + 1 : MAX_FAIL;
        if (exp_fails == MAX_FAIL) begin
            check("locked_out", locked_out, 1);
            check("fail_cnt_lock", fail_cnt, MAX_FAIL);
            lock_len  = 0;
            code_val  = 1'b1;
            code_data = CODE_W'($urandom);
            while (locked_out && lock_len < 100) begin
                check("lock_code_ready", code_ready, 0);
                check("lock_ser_val", ser_val, 0);
                lock_len++;
                @(negedge clk);
            end
            code_val = 1'b0;
            check("lock_len", lock_len, LOCKOUT_CYCLES);
            check("fail_cnt_after_lock", fail_cnt, 0);
            check("code_ready_after_lock", code_ready, 1);
            exp_fails = 0;
            @(negedge clk);
            check("lock_code_dropped", ser_val, 0);
        end else begin
            check("fail_cnt", fail_cnt, exp_fails);
            check("not_locked", locked_out, 0);
            check("code_ready_idle", code_ready, 1);
        end
    endtask

    initial begin
        logic [CODE_W-1:0] code;
        int n, n_bits, delay;
        logic verdict;
        bit lazy;
        code_val = 1'b0; code_data = '0; ser_ready = 1'b0;
        output_val = 1'b0; output_data = 1'b0; rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_code_ready", code_ready, 0);
        check("reset_ser_val", ser_val, 0);
        check("reset_fail_cnt", fail_cnt, 0);
        check("reset_locked_out", locked_out, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("code_ready_after_reset", code_ready, 1);

        // correct code, no stalls, alternating bit/gap
        run_txn(4'b1011, CODE_W, 1'b1, 0, 0, 0, 0, 0);
        // lock rejects after the first bit
        run_txn(4'b0011, 1, 1'b0, 0, 0, 0, 0, 0);
        // 3-cycle stall on bit 2
        run_txn(SECRET, CODE_W, 1'b1, 1, 0, 1, 0, 0);
        // three failures in a row -> lockout
        run_txn(4'b0000, 1, 1'b0, 0, 0, 0, 0, 0);
        run_txn(4'b1111, 2, 1'b0, 1, 0, 0, 0, 0);
        run_txn(4'b1010, CODE_W, 1'b0, 2, 0, 0, 0, 0);
        // one failure, then reset during the gap after bit 2, then a full code
        run_txn(4'b1100, 2, 1'b0, 0, 0, 0, 0, 0);
        run_txn(SECRET, CODE_W, 1'b1, 0, 0, 0, 2, 0);
        run_txn(SECRET, CODE_W, 1'b1, 0, 1, 0, 0, 0);

        // spurious verdict while idle
        @(negedge clk);
        output_val = 1'b1; output_data = 1'b1;
        @(negedge clk);
        output_val = 1'b0;
        check("spurious_no_result", result_val, 0);
        check("spurious_still_idle", code_ready, 1);

        // randomized entries against a lock that knows SECRET
        for (int t = 0; t < 40; t++) begin
            code = ($urandom_range(0, 2) == 0) ? SECRET : CODE_W'($urandom);
            lazy = ($urandom_range(0, 3) == 0);
            n = CODE_W;
            for (int i = CODE_W - 1; i >= 0; i--) begin
                if (code[i] != SECRET[i]) begin
                    n = CODE_W - i;
                    break;
                end
            end
            if (code == SECRET || lazy) begin
                n_bits  = CODE_W;
                verdict = (code == SECRET);
            end else begin
                n_bits  = n;
                verdict = 1'b0;
            end
            delay = (n_bits < CODE_W) ? $urandom_range(0, 1) : $urandom_range(0, 3);
            run_txn(code, n_bits, verdict, delay, 1, 0, 0, 0);
        end

`ifdef TX_TIMEOUT_EN
        // silent lock: timeout verdict exactly RESP_TIMEOUT cycles after last bit
        run_txn(SECRET, CODE_W, 1'b1, 0, 0, 0, 0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
